// File: rtl/led_feedback.sv
`default_nettype none
// ============================================================================
// Module   : led_feedback
// Purpose  : Mastermind-style scoring of a 4-symbol guess against a secret code,
//            held on exact/near LEDs for a fixed display period.
// Revision : 1.0
// ============================================================================
module led_feedback #(
  parameter int unsigned DISPLAY_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] codemaker_code,
  input  logic [11:0] codebreaker_code,
  output logic [3:0]  led_exact,
  output logic [3:0]  led_near,
  output logic [2:0]  exact_count,
  output logic [2:0]  near_count,
  output logic        busy,
  output logic        done
);

  // Counter only has to reach DISPLAY_CYCLES-1, so it can never wrap in SHOW.
  localparam int unsigned     CNT_W    = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISPLAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_EXACT = 3'd2,
    S_NEAR  = 3'd3,
    S_SHOW  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [11:0]       maker_q, maker_d;
  logic [11:0]       guess_q, guess_d;
  logic [3:0]        exact_q, exact_d;
  logic [3:0]        near_q,  near_d;
  logic [3:0]        used_q,  used_d;
  logic [2:0]        ecnt_q,  ecnt_d;
  logic [2:0]        ncnt_q,  ncnt_d;
  logic [1:0]        pos_q,   pos_d;
  logic [3:0]        pair_q,  pair_d;
  logic [CNT_W-1:0]  disp_q,  disp_d;

  logic [1:0]        near_i;
  logic [1:0]        near_j;

  function automatic logic [2:0] sym(input logic [11:0] code, input logic [1:0] k);
    logic [2:0] s;
    case (k)
      2'd3:    s = code[11:9];
      2'd2:    s = code[8:6];
      2'd1:    s = code[5:3];
      default: s = code[2:0];
    endcase
    return s;
  endfunction

  // pair_q counts 15..0: upper bits walk the guess symbol, lower bits the maker symbol.
  assign near_i = pair_q[3:2];
  assign near_j = pair_q[1:0];

  always_comb begin
    state_d = state_q;
    maker_d = maker_q;
    guess_d = guess_q;
    exact_d = exact_q;
    near_d  = near_q;
    used_d  = used_q;
    ecnt_d  = ecnt_q;
    ncnt_d  = ncnt_q;
    pos_d   = pos_q;
    pair_d  = pair_q;
    disp_d  = disp_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        maker_d = codemaker_code;
        guess_d = codebreaker_code;
        exact_d = 4'd0;
        near_d  = 4'd0;
        used_d  = 4'd0;
        ecnt_d  = 3'd0;
        ncnt_d  = 3'd0;
        pos_d   = 2'd3;
        pair_d  = 4'd15;
        state_d = S_EXACT;
      end
      S_EXACT: begin
        if (sym(maker_q, pos_q) == sym(guess_q, pos_q)) begin
          exact_d[pos_q] = 1'b1;
          used_d[pos_q]  = 1'b1;
          ecnt_d         = ecnt_q + 3'd1;
        end
        if (pos_q == 2'd0) begin
          state_d = S_NEAR;
        end else begin
          pos_d = pos_q - 2'd1;
        end
      end
      S_NEAR: begin
        if (!exact_q[near_i] && !near_q[near_i] && !used_q[near_j] &&
            (sym(guess_q, near_i) == sym(maker_q, near_j))) begin
          near_d[near_i] = 1'b1;
          used_d[near_j] = 1'b1;
          ncnt_d         = ncnt_q + 3'd1;
        end
        if (pair_q == 4'd0) begin
          disp_d  = '0;
          state_d = S_SHOW;
        end else begin
          pair_d = pair_q - 4'd1;
        end
      end
      S_SHOW: begin
        if (disp_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          disp_d = disp_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      maker_q <= 12'd0;
      guess_q <= 12'd0;
      exact_q <= 4'd0;
      near_q  <= 4'd0;
      used_q  <= 4'd0;
      ecnt_q  <= 3'd0;
      ncnt_q  <= 3'd0;
      pos_q   <= 2'd0;
      pair_q  <= 4'd0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      maker_q <= maker_d;
      guess_q <= guess_d;
      exact_q <= exact_d;
      near_q  <= near_d;
      used_q  <= used_d;
      ecnt_q  <= ecnt_d;
      ncnt_q  <= ncnt_d;
      pos_q   <= pos_d;
      pair_q  <= pair_d;
      disp_q  <= disp_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign led_exact   = (state_q == S_SHOW) ? exact_q : 4'd0;
  assign led_near    = (state_q == S_SHOW) ? near_q  : 4'd0;
  assign exact_count = ecnt_q;
  assign near_count  = ncnt_q;

endmodule
`default_nettype wire
